smg_scheduler: RTL and testbench
================================

Name: smg_scheduler

Overview:
Time-shares the 4-digit seven-segment display between four 16-bit data sources (motor, sensor, debug, status).
- Rotates round-robin between valid sources, with a programmable dwell time per source.
- Supports a freeze (hold) and a forced selection.
- Multiplexes the four digits, hex-decodes the nibbles and marks the active source with the decimal point.
- Sits between the datapath status registers and the board an/seg pins.

Parameters:
DWELL_CYCLES, 100_000_000, clk cycles each source stays on display (1 s at 100 MHz); must be >= 2
SCAN_CYCLES, 100_000, clk cycles each digit is driven (1 ms); must be >= 1

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
src_data  in  64  four sources; source k = src_data[16k+15:16k]
src_valid  in  4  per-source valid; invalid sources are skipped
hold  in  1  freezes the dwell counter (display content still live)
force_en  in  1  overrides rotation with force_sel
force_sel  in  2  source index shown while force_en=1
an  out  4  digit enables, active-low; an[0] = rightmost digit
seg  out  8  active-low; seg[7]=dp, seg[6:0]=g..a
cur_src  out  2  index of the source being displayed
blank  out  1  1 when nothing is displayed

Behaviour:
Reset:
- state=IDLE, cur_src=0, dwell_cnt=0, scan_cnt=0, digit=0.
- an=4'hF, seg=8'hFF, blank=1.

Rotation FSM: states IDLE, SHOW, FORCE; all outputs registered.
- IDLE:
  - force_en=1 -> FORCE with cur_src=force_sel.
  - else any src_valid bit set -> SHOW with cur_src = lowest valid index.
- SHOW:
  - dwell_cnt increments each cycle unless hold=1.
  - At dwell_cnt==DWELL_CYCLES-1: dwell_cnt<=0; cur_src <= next valid index after cur_src, searching cur_src+1..cur_src+3 mod 4 and wrapping. If cur_src is the only valid source it stays.
  - If src_valid[cur_src] drops: the next cycle moves to the next valid source with dwell_cnt=0, ignoring hold. If none is valid -> IDLE.
  - force_en=1 -> FORCE (priority over all other SHOW transitions).
- FORCE:
  - cur_src=force_sel, tracked every cycle; dwell_cnt held at 0; src_valid is ignored.
  - force_en=0 -> SHOW with dwell_cnt=0 if src_valid[cur_src]=1. Otherwise apply the SHOW invalid-source rule: next valid source, or IDLE.
- disp_word register <= selected source data every cycle (live values, 1-cycle latency).

Scanner, independent of the FSM:
- scan_cnt counts 0..SCAN_CYCLES-1; at the terminal count digit <= digit+1 (wraps 3->0).
- an = ~(1<<digit).
- seg[6:0] = hex pattern of disp_word[4*digit+3:4*digit].
- seg[7] = 0 (dp lit) iff digit==cur_src.
- In IDLE: an=4'hF, seg=8'hFF, blank=1. The scanner keeps counting.
- Hex table (seg[6:0], active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- an/seg update one cycle after a digit or cur_src change.

Edge cases:
- Terminal count and invalidation in the same cycle: the invalidation rule wins; the result is the same next source.
- hold during FORCE has no effect.
- Reset mid-dwell or mid-scan returns to the reset values immediately.

Decomposition:
- smg_pkg holds:
  - state encoding (IDLE/SHOW/FORCE, 2 bits)
  - 16-entry hex-to-segment constant table
  - SEG_BLANK=8'hFF and AN_OFF=4'hF
- Sub-module smg_scan_driver: scan counter, digit select, hex decode, dp and blanking. Inputs are disp_word, cur_src and blank.
- The FSM and dwell counter stay in smg_scheduler.

Test Plan:
All tests use DWELL_CYCLES=8 and SCAN_CYCLES=2.
1. Reset, src_valid=4'b0000:
   - an=4'hF, seg=8'hFF, blank=1 held for 50 cycles.
2. src_valid=4'b1111, sources = 16'h0123 / 16'h4567 / 16'h89AB / 16'hCDEF:
   - cur_src steps 0,1,2,3,0 every 8 cycles.
   - With cur_src=0, digit 0 shows seg=8'h30 ('3', dp lit on digit 0) and digit 3 shows 8'hC0 ('0', dp off).
3. src_valid=4'b1010:
   - cur_src alternates 1,3,1.
   - Clearing bit 3 mid-dwell moves cur_src to 1 on the next cycle with dwell_cnt=0.
4. hold=1 for 20 cycles in SHOW:
   - cur_src is unchanged.
   - Changing src_data appears on seg within 2 cycles of the digit being scanned.
5. force_en=1, force_sel=2, src_valid=4'b0001:
   - cur_src=2 and data is shown despite the source being invalid.
   - Release -> cur_src=0 next cycle, then rotation resumes.
6. Assert rst mid-dwell with cur_src=3:
   - an=4'hF, seg=8'hFF, cur_src=0 in the same cycle.
   - After release, rotation restarts from the lowest valid source.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared types and constants for the seven-segment display scheduler:
// FSM encoding, hex-to-segment table and round-robin search helpers.
package smg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low g..a patterns for 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // {found, index}: first valid source after cur, searching cur+1..cur+3 mod 4
    function automatic logic [2:0] next_valid(input logic [1:0] cur, input logic [3:0] valid);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, cur};
        for (int i = 3; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (valid[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [1:0] lowest_valid(input logic [3:0] valid);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (valid[i]) res = 2'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/smg_scan_driver.sv
// Digit multiplexer: free-running scan counter, hex decode, decimal-point
// marker for the active source and blanking. All outputs registered.
module smg_scan_driver
    import smg_pkg::*;
#(
    parameter int SCAN_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] disp_word,
    input  logic [1:0]  cur_src,
    input  logic        blank_in,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        blank
);

    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit;
    logic [3:0]    nibble;

    assign nibble = disp_word[{digit, 2'b00} +: 4];

    // Scanner runs regardless of blanking so the digit phase never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
            blank <= 1'b1;
        end else if (blank_in) begin
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
            blank <= 1'b1;
        end else begin
            an    <= ~(4'b0001 << digit);
            seg   <= {digit != cur_src, HEX_SEG[nibble]};
            blank <= 1'b0;
        end
    end

endmodule

// File: rtl/smg_scheduler.sv
// Round-robin time-sharing of the 4-digit display between four 16-bit
// sources, with dwell timer, hold, forced selection and registered outputs.
module smg_scheduler
    import smg_pkg::*;
#(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int SCAN_CYCLES  = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] src_data,
    input  logic [3:0]  src_valid,
    input  logic        hold,
    input  logic        force_en,
    input  logic [1:0]  force_sel,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [1:0]  cur_src,
    output logic        blank,
    output state_t      state_dbg
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    state_t        state, state_n;
    logic [1:0]    cur_n;
    logic [DW-1:0] dwell_cnt, dwell_n;
    logic [2:0]    nv;
    logic [15:0]   disp_word;

    assign state_dbg = state;
    assign nv        = next_valid(cur_src, src_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_src   <= 2'd0;
            dwell_cnt <= '0;
            disp_word <= 16'h0000;
        end else begin
            state     <= state_n;
            cur_src   <= cur_n;
            dwell_cnt <= dwell_n;
            disp_word <= src_data[{cur_src, 4'b0000} +: 16];
        end
    end

    // Invalidation of the shown source outranks hold and the dwell terminal count
    always_comb begin
        state_n = state;
        cur_n   = cur_src;
        dwell_n = dwell_cnt;
        case (state)
            ST_IDLE: begin
                dwell_n = '0;
                if (force_en) begin
                    state_n = ST_FORCE;
                    cur_n   = force_sel;
                end else if (|src_valid) begin
                    state_n = ST_SHOW;
                    cur_n   = lowest_valid(src_valid);
                end
            end
            ST_SHOW: begin
                if (force_en) begin
                    state_n = ST_FORCE;
                    cur_n   = force_sel;
                    dwell_n = '0;
                end else if (!src_valid[cur_src]) begin
                    dwell_n = '0;
                    if (nv[2]) cur_n = nv[1:0];
                    else       state_n = ST_IDLE;
                end else if (!hold) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_n = '0;
                        if (nv[2]) cur_n = nv[1:0];
                    end else begin
                        dwell_n = dwell_cnt + DW'(1);
                    end
                end
            end
            ST_FORCE: begin
                dwell_n = '0;
                if (force_en) begin
                    cur_n = force_sel;
                end else if (src_valid[cur_src]) begin
                    state_n = ST_SHOW;
                end else if (nv[2]) begin
                    state_n = ST_SHOW;
                    cur_n   = nv[1:0];
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                dwell_n = '0;
            end
        endcase
    end

    smg_scan_driver #(
        .SCAN_CYCLES(SCAN_CYCLES)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .disp_word(disp_word),
        .cur_src  (cur_src),
        .blank_in (state == ST_IDLE),
        .an       (an),
        .seg      (seg),
        .blank    (blank)
    );

endmodule

// File: tb/tb_smg_scheduler.sv
// Directed bench for smg_scheduler (DWELL_CYCLES=8, SCAN_CYCLES=2): stimulus
// pushes cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_smg_scheduler;
    import smg_pkg::*;

    localparam int DWELL = 8;
    localparam int SCAN  = 2;

    logic        clk;
    logic        rst;
    logic [63:0] src_data;
    logic [3:0]  src_valid;
    logic        hold;
    logic        force_en;
    logic [1:0]  force_sel;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  cur_src;
    logic        blank;
    state_t      state_dbg;

    smg_scheduler #(
        .DWELL_CYCLES(DWELL),
        .SCAN_CYCLES (SCAN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src_data (src_data),
        .src_valid(src_valid),
        .hold     (hold),
        .force_en (force_en),
        .force_sel(force_sel),
        .an       (an),
        .seg      (seg),
        .cur_src  (cur_src),
        .blank    (blank),
        .state_dbg(state_dbg)
    );

    // Clock / reset / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned rel_cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL timeout: cycle=%0d required=finish before time limit", cyc);
        $fatal(1, "timeout");
    end

    // Scoreboard: mask bit0=cur_src, bit1=an/seg, bit2=blank, bit3=state
    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  mask;
        logic [1:0]  cur;
        logic [3:0]  an;
        logic [7:0]  seg;
        logic        blank;
        logic [1:0]  st;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s @cycle %0d: actual=%0h required=%0h", name, cyc, act, exp_v);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Digit whose an/seg are on the pins at the negedge after posedge number c
    function automatic int digit_at(input int unsigned c);
        return int'((c - 1 - rel_cyc) / SCAN) % 4;
    endfunction

    task automatic push_exp(input int unsigned delta, input logic [3:0] mask, input logic [1:0] cur,
                            input logic [3:0] an_e, input logic [7:0] seg_e, input logic blank_e,
                            input logic [1:0] st_e);
        exp_t e;
        e.cyc = cyc + delta;  e.mask = mask;  e.cur = cur;  e.an = an_e;
        e.seg = seg_e;        e.blank = blank_e;  e.st = st_e;
        exp_q.push_back(EXP_W'(e));
    endtask

    task automatic exp_cur(input int unsigned delta, input logic [1:0] s);
        push_exp(delta, 4'b0001, s, 4'h0, 8'h00, 1'b0, 2'd0);
    endtask

    task automatic exp_idle(input int unsigned delta);
        push_exp(delta, 4'b1111, 2'd0, 4'hF, 8'hFF, 1'b1, ST_IDLE);
    endtask

    task automatic exp_disp(input int unsigned delta, input logic [15:0] word, input logic [1:0] dp_src);
        int d;
        logic [3:0] nib;
        d   = digit_at(cyc + delta);
        nib = word[4*d +: 4];
        push_exp(delta, 4'b0110, 2'd0, ~(4'b0001 << d), {d != int'(dp_src), hex7(nib)}, 1'b0, 2'd0);
    endtask

    // Monitor
    exp_t mon_e;
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            mon_e = exp_t'(exp_q[i]);
            if (mon_e.cyc == cyc) begin
                if (mon_e.mask[0]) check("cur_src", 32'(cur_src), 32'(mon_e.cur));
                if (mon_e.mask[1]) check("an", 32'(an), 32'(mon_e.an));
                if (mon_e.mask[1]) check("seg", 32'(seg), 32'(mon_e.seg));
                if (mon_e.mask[2]) check("blank", 32'(blank), 32'(mon_e.blank));
                if (mon_e.mask[3]) check("state", 32'(state_dbg), 32'(mon_e.st));
                exp_q.delete(i);
            end else if (mon_e.cyc < cyc) begin
                check("stale_expect", cyc, mon_e.cyc);
                exp_q.delete(i);
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = 4'b0000;
        hold      = 1'b0;
        force_en  = 1'b0;
        force_sel = 2'd0;
        tick(2);
        rst     = 1'b0;
        rel_cyc = cyc;
    endtask

    localparam logic [63:0] WORDS = 64'hCDEF_89AB_4567_0123;

    initial begin
        rst       = 1'b1;
        src_data  = WORDS;
        src_valid = 4'b0000;
        hold      = 1'b0;
        force_en  = 1'b0;
        force_sel = 2'd0;

        // 1: reset, nothing valid -> blank for 50 cycles
        do_reset();
        for (int d = 0; d <= 50; d++) exp_idle(d);
        tick(50);

        // 2: all valid, rotation 0,1,2,3,0 every 8 cycles
        do_reset();
        src_data  = WORDS;
        src_valid = 4'b1111;
        exp_cur(1, 0);  exp_cur(8, 0);  exp_cur(9, 1);  exp_cur(16, 1);
        exp_cur(17, 2); exp_cur(25, 3); exp_cur(32, 3); exp_cur(33, 0);
        for (int d = 3; d <= 9; d++) begin
            if (digit_at(cyc + d) == 0) push_exp(d, 4'b0010, 2'd0, 4'hE, 8'h30, 1'b0, 2'd0);
            if (digit_at(cyc + d) == 3) push_exp(d, 4'b0010, 2'd0, 4'h7, 8'hC0, 1'b0, 2'd0);
            exp_disp(d, 16'h0123, 2'd0);
        end
        for (int d = 19; d <= 25; d++) exp_disp(d, 16'h89AB, 2'd2);
        tick(36);

        // 3: sources 1 and 3 alternate; dropping 3 mid-dwell snaps back to 1
        do_reset();
        src_valid = 4'b1010;
        exp_cur(1, 1);  exp_cur(8, 1);  exp_cur(9, 3);  exp_cur(16, 3);
        exp_cur(17, 1); exp_cur(25, 3);
        for (int d = 11; d <= 17; d++) exp_disp(d, 16'hCDEF, 2'd3);
        tick(28);
        exp_cur(0, 3);
        src_valid = 4'b0010;
        tick(1);
        exp_cur(0, 1);
        src_valid = 4'b1010;
        exp_cur(7, 1);
        exp_cur(8, 3);
        tick(10);

        // 4: hold for 20 cycles freezes rotation; data stays live
        do_reset();
        src_valid = 4'b1111;
        exp_cur(1, 0);  exp_cur(10, 0); exp_cur(24, 0); exp_cur(28, 0); exp_cur(29, 1);
        for (int d = 5; d <= 11; d++) exp_disp(d, 16'h0123, 2'd0);
        for (int d = 12; d <= 20; d++) exp_disp(d, 16'hA5C3, 2'd0);
        tick(4);
        hold = 1'b1;
        tick(6);
        src_data[15:0] = 16'hA5C3;
        tick(14);
        hold = 1'b0;
        tick(8);
        src_data = WORDS;

        // 5: forced selection of an invalid source, then release
        do_reset();
        src_valid = 4'b0001;
        force_en  = 1'b1;
        force_sel = 2'd2;
        exp_cur(1, 2); exp_cur(10, 2); exp_cur(12, 2);
        for (int d = 3; d <= 12; d++) exp_disp(d, 16'h89AB, 2'd2);
        tick(12);
        force_en = 1'b0;
        tick(1);
        exp_cur(0, 0);
        src_valid = 4'b0011;
        exp_cur(7, 0);
        exp_cur(8, 1);
        tick(10);

        // 6: reset mid-dwell while showing source 3
        do_reset();
        src_valid = 4'b1111;
        exp_cur(25, 3);
        tick(28);
        rst = 1'b1;
        exp_idle(0);
        tick(2);
        rst     = 1'b0;
        rel_cyc = cyc;
        exp_cur(1, 0);
        exp_cur(8, 0);
        exp_cur(9, 1);
        tick(12);

        tick(3);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
